cp0_unit: RTL

Parametrised coprocessor-0 for the MIPS-style core. It handles MFC0/MTC0 access, synchronous exceptions and masked hardware interrupts, and keeps a nested-exception stack of the interrupt-enable bit. An optional Count/Compare timer is included. It sits beside the register file in the execute/writeback stage, and the PC-select logic consumes `exc_taken`/`exc_vector`/`epc_out`.

---
 rtl/cp0_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 for the MIPS-style core.
// Handles MFC0/MTC0, synchronous exceptions, masked hardware interrupts and a
// nested stack of the saved interrupt-enable bit. All state updates happen on
// the falling edge of cp0_clk.
// Optional feature macro: CP0_TIMER_EN adds the Count/Compare timer
// (registers 9/11, pending bit Cause.IP[7]). Without it, those registers
// read 0 and IP[7] is tied to 0.
module cp0_unit #(
  parameter int          NUM_IRQ     = 5,
  parameter int          STACK_DEPTH = 3,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004
) (
  input  logic               cp0_clk,
  input  logic               cp0_rst,
  input  logic               cp0_ena,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic               eret,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic [31:0]        pc,
  input  logic [4:0]         addr,
  input  logic [31:0]        data_in,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        cp0_out,
  output logic [31:0]        epc_out,
  output logic               exc_taken,
  output logic [31:0]        exc_vector,
  output logic               irq_pending
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [3:0] DEPTH_L     = 4'(STACK_DEPTH);

  logic                   ie;
  logic                   ovf;
  logic [7:0]             im;
  logic [1:0]             ip_sw;
  logic [NUM_IRQ-1:0]     ip_hw;
  logic                   ip_tmr;
  logic [4:0]             exc_code_r;
  logic [31:0]            epc;
  logic [3:0]             level;
  // Saved IE bits, newest in bit 0; shifting left on a full push drops the oldest.
  logic [STACK_DEPTH-1:0] ie_stack;

  logic [4:0]  ip_hw_ext;
  logic [7:0]  ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;
  logic [31:0] rd_data;
  logic        pend_raw;
  logic        int_req;
  logic        take;
  logic        do_mtc0;
  logic        do_eret;

  // Place the hardware interrupt lines at IP[2+i]; unused lines read 0.
  always_comb begin
    ip_hw_ext = '0;
    ip_hw_ext[NUM_IRQ-1:0] = ip_hw;
  end

  assign ip        = {ip_tmr, ip_hw_ext, ip_sw};
  assign pend_raw  = |(ip & im);
  assign int_req   = ie && pend_raw && !exc_req;
  assign take      = cp0_ena && !cp0_rst && (exc_req || int_req);
  assign do_mtc0   = cp0_ena && mtc0 && !exc_req && !int_req;
  assign do_eret   = cp0_ena && eret && !exc_req && !int_req && !mtc0;

  assign status_rd = {level, 12'b0, im, 5'b0, ovf, (level != 4'd0), ie};
  assign cause_rd  = {16'b0, ip, 1'b0, exc_code_r, 2'b0};

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;

  // Free-running Count; an MTC0 to Count replaces the increment, a Compare
  // write clears the pending bit and wins over a same-edge match.
  always_ff @(negedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      count   <= '0;
      compare <= '0;
      ip_tmr  <= 1'b0;
    end else if (cp0_ena) begin
      if (do_mtc0 && addr == REG_COUNT) begin
        count <= data_in;
      end else begin
        count <= count + 32'd1;
        if (count + 32'd1 == compare) ip_tmr <= 1'b1;
      end
      if (do_mtc0 && addr == REG_COMPARE) begin
        compare <= data_in;
        ip_tmr  <= 1'b0;
      end
    end
  end
`else
  assign ip_tmr = 1'b0;
`endif

  // MFC0 read mux over the implemented registers.
  always_comb begin
    rd_data = '0;
    case (addr)
`ifdef CP0_TIMER_EN
      REG_COUNT:   rd_data = count;
      REG_COMPARE: rd_data = compare;
`endif
      REG_STATUS:  rd_data = status_rd;
      REG_CAUSE:   rd_data = cause_rd;
      REG_EPC:     rd_data = epc;
      default:     rd_data = '0;
    endcase
  end

  // Architectural state: one action per enabled edge, exception/interrupt
  // entry first, then MTC0, then ERET.
  always_ff @(negedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      ie         <= 1'b0;
      ovf        <= 1'b0;
      im         <= '0;
      ip_sw      <= '0;
      ip_hw      <= '0;
      exc_code_r <= '0;
      epc        <= '0;
      level      <= '0;
      ie_stack   <= '0;
    end else if (cp0_ena) begin
      ip_hw <= irq;
      if (take) begin
        epc        <= pc;
        exc_code_r <= exc_req ? exc_code : 5'd0;
        ie_stack   <= (ie_stack << 1) | STACK_DEPTH'(ie);
        ie         <= 1'b0;
        if (level < DEPTH_L) level <= level + 4'd1;
        else                 ovf   <= 1'b1;
      end else if (do_mtc0) begin
        case (addr)
          REG_STATUS: begin
            ie <= data_in[0];
            if (!data_in[2]) ovf <= 1'b0;
            im <= data_in[15:8];
          end
          REG_CAUSE: ip_sw <= data_in[9:8];
          REG_EPC:   epc   <= data_in;
          default:   ;
        endcase
      end else if (do_eret && level != 4'd0) begin
        ie       <= ie_stack[0];
        ie_stack <= ie_stack >> 1;
        level    <= level - 4'd1;
      end
    end
  end

  assign cp0_out     = (mfc0 && cp0_ena) ? rd_data : '0;
  assign epc_out     = (eret && cp0_ena) ? epc : '0;
  assign exc_taken   = take;
  assign exc_vector  = take ? EXC_VECTOR : '0;
  assign irq_pending = cp0_ena && pend_raw;

endmodule
